// File: rtl/led_pkg.sv
// Shared constants, enums and command-word helper for the LED frame sequencer.
package led_pkg;

    localparam int WORD_W  = 16;
    localparam int N_WORDS = 25;
    localparam int FRAME_W = WORD_W * N_WORDS;

    localparam logic [15:0] INDEX_CMD = 16'h4C45;

    localparam logic [63:0] INIT_ROM [0:3] = '{
        64'hAE00_0000_0000_0001,
        64'hD5F0_1122_3344_5502,
        64'h8D14_A0C8_DA12_8103,
        64'hD9F1_DB40_A4A6_AF04
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_INDEX,
        PH_DATA
    } phase_t;

    // 64-bit word presented on init_in for a given phase; data phase reuses the index word.
    function automatic logic [63:0] cmd_word(input phase_t ph, input logic [1:0] idx);
        return (ph == PH_INIT) ? INIT_ROM[idx] : {INDEX_CMD, 48'h0};
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Host-writable 25x16 working buffer plus the snapshot register that feeds spi_master.
module led_frame_buffer
    import led_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [4:0]         wr_addr,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               snap,
    output logic [FRAME_W-1:0] frame_out
);

    logic [WORD_W-1:0]  r_words [N_WORDS];
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_flat;

    // Word 0 lands in the top bits so it is shifted out first.
    always_comb begin
        w_flat = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            w_flat[FRAME_W-1-WORD_W*k -: WORD_W] = r_words[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_WORDS; k++) begin
                r_words[k] <= '0;
            end
        end else if (wr_en && (wr_addr < 5'(N_WORDS))) begin
            r_words[wr_addr] <= wr_data;
        end
    end

    // Snapshot samples the pre-write contents, so a same-edge write misses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (snap) begin
            r_frame <= w_flat;
        end
    end

    assign frame_out = r_frame;

endmodule

// File: rtl/led_frame_sequencer.sv
// LED frame sequencer: buffers a 400-bit frame and drives spi_master through
// init, index and data transactions using the start/done handshake.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int N_INIT     = 2,
    parameter int GAP_CYCLES = 16,
    parameter int ACK_TO     = 8,
    parameter int DONE_TO    = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [4:0]         wr_addr,
    input  logic [15:0]        wr_data,
    input  logic               refresh,
    input  logic               reinit,
    output logic               busy,
    output logic               frame_done,
    output logic               err,
    output logic               spi_start,
    output logic               spi_index,
    output logic               spi_data,
    output logic [63:0]        spi_init_in,
    output logic [FRAME_W-1:0] spi_data_in,
    input  logic               spi_done
);

    localparam int T_MAX   = (DONE_TO > ACK_TO) ? DONE_TO : ACK_TO;
    localparam int CNT_MAX = (T_MAX > GAP_CYCLES) ? T_MAX : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [1:0] IDX_LAST = 2'(N_INIT - 1);

    state_t             r_state;
    phase_t             r_phase;
    logic [1:0]         r_init_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_init_pend;
    logic               r_reinit_seen;
    logic               r_req_pend;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_err;
    logic               r_start;
    logic               r_index;
    logic               r_data;
    logic [63:0]        r_init_in;

    logic               w_accept;
    logic               w_last_init;
    phase_t             w_nxt_phase;
    logic [1:0]         w_nxt_idx;
    logic [FRAME_W-1:0] w_frame;

    assign w_accept    = (r_state == ST_IDLE) && (refresh || r_req_pend);
    assign w_last_init = (r_phase == PH_INIT) && (r_init_idx == IDX_LAST);

    led_frame_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .snap      (w_accept),
        .frame_out (w_frame)
    );

    // Phase to load next: first phase of a frame from IDLE, otherwise the successor.
    always_comb begin
        w_nxt_phase = r_phase;
        w_nxt_idx   = r_init_idx;
        if (r_state == ST_IDLE) begin
            w_nxt_phase = r_init_pend ? PH_INIT : PH_INDEX;
            w_nxt_idx   = '0;
        end else begin
            case (r_phase)
                PH_INIT: begin
                    if (r_init_idx == IDX_LAST) begin
                        w_nxt_phase = PH_INDEX;
                    end else begin
                        w_nxt_idx = r_init_idx + 2'd1;
                    end
                end
                PH_INDEX: w_nxt_phase = PH_DATA;
                default:  w_nxt_phase = r_phase;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= PH_INIT;
            r_init_idx    <= '0;
            r_cnt         <= '0;
            r_init_pend   <= 1'b1;
            r_reinit_seen <= 1'b0;
            r_req_pend    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err         <= 1'b0;
            r_start       <= 1'b0;
            r_index       <= 1'b0;
            r_data        <= 1'b0;
            r_init_in     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (refresh && (r_state != ST_IDLE)) begin
                r_req_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_pend    <= 1'b0;
                        r_reinit_seen <= 1'b0;
                        r_busy        <= 1'b1;
                        r_err         <= 1'b0;
                        r_phase       <= w_nxt_phase;
                        r_init_idx    <= w_nxt_idx;
                        r_index       <= (w_nxt_phase == PH_INDEX);
                        r_data        <= (w_nxt_phase == PH_DATA);
                        r_init_in     <= cmd_word(w_nxt_phase, w_nxt_idx);
                        r_state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    if (!spi_done) begin
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(ACK_TO - 1)) begin
                        r_start <= 1'b0;
                        r_index <= 1'b0;
                        r_data  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (spi_done) begin
                        // A reinit seen during this frame keeps the next frame's init sequence.
                        if (w_last_init && !r_reinit_seen) begin
                            r_init_pend <= 1'b0;
                        end
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else if (r_cnt == CNT_W'(DONE_TO - 1)) begin
                        r_index <= 1'b0;
                        r_data  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        if (r_phase == PH_DATA) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_index      <= 1'b0;
                            r_data       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_phase    <= w_nxt_phase;
                            r_init_idx <= w_nxt_idx;
                            r_index    <= (w_nxt_phase == PH_INDEX);
                            r_data     <= (w_nxt_phase == PH_DATA);
                            r_init_in  <= cmd_word(w_nxt_phase, w_nxt_idx);
                            r_state    <= ST_ISSUE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            if (reinit) begin
                r_init_pend   <= 1'b1;
                r_reinit_seen <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign err         = r_err;
    assign spi_start   = r_start;
    assign spi_index   = r_index;
    assign spi_data    = r_data;
    assign spi_init_in = r_init_in;
    assign spi_data_in = w_frame;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed/randomized bench for led_frame_sequencer with a behavioural spi_master
// and a transaction-level reference of the expected frame contents.
module tb_led_frame_sequencer;
    import led_pkg::*;

    localparam int N_INIT     = 2;
    localparam int GAP_CYCLES = 16;
    localparam int ACK_TO     = 8;
    localparam int DONE_TO    = 2048;

    typedef struct {
        logic         idx;
        logic         dat;
        logic [63:0]  init;
        logic [399:0] din;
    } tx_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [15:0]  wr_data = '0;
    logic         refresh = 1'b0;
    logic         reinit = 1'b0;
    logic         busy, frame_done, err, spi_start, spi_index, spi_data;
    logic [63:0]  spi_init_in;
    logic [399:0] spi_data_in;
    logic         spi_done = 1'b1;

    always #5 clk = ~clk;

    led_frame_sequencer #(
        .N_INIT(N_INIT), .GAP_CYCLES(GAP_CYCLES), .ACK_TO(ACK_TO), .DONE_TO(DONE_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh(refresh), .reinit(reinit), .busy(busy), .frame_done(frame_done), .err(err),
        .spi_start(spi_start), .spi_index(spi_index), .spi_data(spi_data),
        .spi_init_in(spi_init_in), .spi_data_in(spi_data_in), .spi_done(spi_done)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] shadow [25];
    tx_t         tx_q[$];
    int          fd_cnt = 0;
    int          rise_cnt = 0;
    logic        start_prev = 1'b0;
    bit          m_stuck = 1'b0;
    int          m_lat_fix = 0;
    logic        m_busy = 1'b0;
    logic        start_q = 1'b0;
    int          m_cnt = 0;

    // Behavioural spi_master: rising start drops done, serves for a few cycles, raises done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_done <= 1'b1;
            m_busy   <= 1'b0;
            start_q  <= 1'b0;
            m_cnt    <= 0;
        end else begin
            start_q <= spi_start;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    spi_done <= 1'b1;
                    m_busy   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (spi_start && !start_q && !m_stuck) begin
                spi_done <= 1'b0;
                m_busy   <= 1'b1;
                m_cnt    <= (m_lat_fix > 0) ? m_lat_fix : int'($urandom_range(12, 2));
                tx_q.push_back('{spi_index, spi_data, spi_init_in, spi_data_in});
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (spi_start && !start_prev) rise_cnt++;
        start_prev = spi_start;
    end

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [4:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < 5'd25) shadow[a] = d;
    endtask

    function automatic logic [399:0] exp_frame();
        logic [399:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) v[399-16*k -: 16] = shadow[k];
        return v;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"},        400'(busy),        400'(0));
        chk({tag, " frame_done"},  400'(frame_done),  400'(0));
        chk({tag, " err"},         400'(err),         400'(0));
        chk({tag, " spi_start"},   400'(spi_start),   400'(0));
        chk({tag, " spi_index"},   400'(spi_index),   400'(0));
        chk({tag, " spi_data"},    400'(spi_data),    400'(0));
        chk({tag, " spi_init_in"}, 400'(spi_init_in), 400'(0));
        chk({tag, " spi_data_in"}, spi_data_in,       400'(0));
    endtask

    // refresh sampled at edge T; busy and start must both be up after edge T+1.
    task automatic accept(input string tag);
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        tick();
        chk({tag, " accept busy"},  400'(busy),      400'(1));
        chk({tag, " accept start"}, 400'(spi_start), 400'(1));
        chk({tag, " accept err"},   400'(err),       400'(0));
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (fd_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " frame_done seen"}, 400'(fd_cnt >= target), 400'(1));
    endtask

    task automatic check_frame(input string tag, input bit with_init, input int base,
                               input logic [399:0] exp_din);
        int n_exp;
        int p;
        n_exp = with_init ? N_INIT + 2 : 2;
        chk({tag, " tx available"}, 400'(tx_q.size() >= base + n_exp), 400'(1));
        if (tx_q.size() >= base + n_exp) begin
            p = base;
            if (with_init) begin
                for (int i = 0; i < N_INIT; i++) begin
                    chk({tag, " init mode"}, 400'({tx_q[p].idx, tx_q[p].dat}), 400'(2'b00));
                    chk({tag, " init word"}, 400'(tx_q[p].init), 400'(INIT_ROM[i]));
                    p++;
                end
            end
            chk({tag, " index mode"}, 400'({tx_q[p].idx, tx_q[p].dat}), 400'(2'b10));
            chk({tag, " index word"}, 400'(tx_q[p].init), 400'({INDEX_CMD, 48'h0}));
            p++;
            chk({tag, " data mode"}, 400'({tx_q[p].idx, tx_q[p].dat}), 400'(2'b01));
            chk({tag, " data frame"}, tx_q[p].din, exp_din);
        end
    endtask

    task automatic run_frame(input string tag, input bit with_init, input bit mid_write,
                             input logic [15:0] mid_word);
        int base, f0, r0, n_exp;
        logic [399:0] snap;
        base  = tx_q.size();
        f0    = fd_cnt;
        r0    = rise_cnt;
        snap  = exp_frame();
        n_exp = with_init ? N_INIT + 2 : 2;
        accept(tag);
        if (mid_write) begin
            write_word(5'd0, mid_word);
            chk({tag, " snapshot word0"}, 400'(spi_data_in[399:384]), 400'(snap[399:384]));
        end
        wait_frames(f0 + 1, 3000, tag);
        tick(2);
        chk({tag, " start rises"}, 400'(rise_cnt - r0), 400'(n_exp));
        chk({tag, " tx count"},    400'(tx_q.size() - base), 400'(n_exp));
        chk({tag, " one frame"},   400'(fd_cnt - f0), 400'(1));
        chk({tag, " busy low"},    400'(busy), 400'(0));
        chk({tag, " err low"},     400'(err), 400'(0));
        check_frame(tag, with_init, base, snap);
    endtask

    initial begin
        int base, f0, r0, n;
        logic [399:0] snap;

        for (int k = 0; k < 25; k++) shadow[k] = '0;
        tick(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick(2);

        for (int k = 0; k < 25; k++) write_word(5'(k), 16'($urandom));
        for (int a = 25; a < 32; a++) write_word(5'(a), 16'($urandom));

        run_frame("first", 1'b1, 1'b0, 16'h0);
        run_frame("second", 1'b0, 1'b0, 16'h0);

        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        tick();
        run_frame("reinit", 1'b1, 1'b0, 16'h0);

        write_word(5'd0, 16'hA5A5);
        run_frame("snap", 1'b0, 1'b1, 16'h1234);
        run_frame("snap next", 1'b0, 1'b0, 16'h0);
        chk("snap next word0", 400'(spi_data_in[399:384]), 400'(16'h1234));

        // Three requests while busy coalesce into a single follow-up frame.
        for (int k = 0; k < 4; k++) write_word(5'($urandom_range(24, 0)), 16'($urandom));
        base = tx_q.size();
        f0   = fd_cnt;
        r0   = rise_cnt;
        snap = exp_frame();
        accept("coal");
        for (int i = 0; i < 3; i++) begin
            tick(5);
            refresh = 1'b1;
            tick();
            refresh = 1'b0;
        end
        wait_frames(f0 + 2, 6000, "coal");
        tick(300);
        chk("coal frames", 400'(fd_cnt - f0), 400'(2));
        chk("coal rises",  400'(rise_cnt - r0), 400'(4));
        chk("coal busy",   400'(busy), 400'(0));
        check_frame("coal a", 1'b0, base, snap);
        check_frame("coal b", 1'b0, base + 2, snap);

        // Master never acknowledges: expect a timeout abort.
        m_stuck = 1'b1;
        f0 = fd_cnt;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        n = 0;
        while (!err && n < ACK_TO + 20) begin
            tick();
            n++;
        end
        chk("ackto err",       400'(err), 400'(1));
        chk("ackto latency",   400'((n >= ACK_TO) && (n <= ACK_TO + 2)), 400'(1));
        chk("ackto busy",      400'(busy), 400'(0));
        chk("ackto start",     400'(spi_start), 400'(0));
        chk("ackto index",     400'(spi_index), 400'(0));
        chk("ackto data",      400'(spi_data), 400'(0));
        tick(GAP_CYCLES);
        chk("ackto no frame",  400'(fd_cnt - f0), 400'(0));
        chk("ackto err stays", 400'(err), 400'(1));
        m_stuck = 1'b0;
        tick(3);
        run_frame("after timeout", 1'b0, 1'b0, 16'h0);

        // Reset while the data transaction is in flight.
        m_lat_fix = 60;
        accept("midrst");
        n = 0;
        while (!(spi_data && !spi_done) && n < 2000) begin
            tick();
            n++;
        end
        chk("midrst reached data", 400'(spi_data && !spi_done), 400'(1));
        tick(3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick(2);
        rst_n = 1'b1;
        m_lat_fix = 0;
        for (int k = 0; k < 25; k++) shadow[k] = '0;
        tick();
        for (int k = 0; k < 5; k++) write_word(5'($urandom_range(24, 0)), 16'($urandom));
        run_frame("post reset", 1'b1, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
